// File: rtl/therm_sort_sched_pkg.sv
// Shared types and helpers for the thermometer batch sorter.
package therm_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  // Valid thermometer code is 0..01..1; the caller zero-extends the word.
  function automatic bit is_therm(input logic [63:0] w);
    return (w & (w + 64'd1)) == 64'd0;
  endfunction

  // Number of compare-exchange steps for an odd-even transposition over k words.
  function automatic int num_compares(input int k);
    int c;
    c = 0;
    for (int r = 0; r < k; r++) c += (k - (r % 2)) / 2;
    return c;
  endfunction

endpackage

// File: rtl/therm_sort_sched_if.sv
// Input/output stream bundle of the thermometer sorter plus its status flags.
interface therm_sort_sched_if #(parameter int N = 4);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/therm_sort_sched_cmp_exch.sv
// Compare-exchange for thermometer codes: AND gives the min, OR the max.
module therm_cmp_exch #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] min,
  output logic [N-1:0] max
);
  assign min = a & b;
  assign max = a | b;
endmodule

// File: rtl/therm_sort_sched.sv
// Loads K thermometer words, sorts them with one shared compare-exchange cell
// stepped through an odd-even transposition network, then streams them out ascending.
module therm_sort_sched
  import therm_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst,
  therm_sort_sched_if.slave bus
);
  localparam int            IW   = $clog2(K);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t                state, state_nx;
  logic [K-1:0][N-1:0]   store;
  logic [IW-1:0]         load_idx, out_idx, round, pi, pj;
  logic                  err_q;
  logic                  in_hs, out_hs, last_pair, next_has, sort_done;
  logic [N-1:0]          mn, mx;

  assign in_hs  = bus.in_valid  && (state == LOAD);
  assign out_hs = bus.out_ready && (state == DRAIN);
  assign pj     = pi + IW'(1);

  // Last pair of a round, and whether the following round has any pair at all
  // (an odd-start round needs K > 2); the sort ends when no round remains.
  assign last_pair = (int'(pi) + 3 >= K);
  assign next_has  = (int'(round) + 1 < K) && (round[0] || K > 2);
  assign sort_done = last_pair && !next_has;

  therm_cmp_exch #(.N(N)) u_cx (
    .a   (store[pi]),
    .b   (store[pj]),
    .min (mn),
    .max (mx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_hs && load_idx == LAST)  state_nx = SORT;
      SORT:    if (sort_done)                  state_nx = DRAIN;
      DRAIN:   if (out_hs && out_idx == LAST)  state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    case (state)
      LOAD: bus.in_ready = 1'b1;
      SORT: bus.busy     = 1'b1;
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out_data  = store[out_idx];
        bus.out_last  = (out_idx == LAST);
      end
      default: ;
    endcase
  end

  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      store    <= '0;
      load_idx <= '0;
      out_idx  <= '0;
      round    <= '0;
      pi       <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          round <= '0;
          pi    <= '0;
          if (in_hs) begin
            store[load_idx] <= bus.in_data;
            load_idx        <= (load_idx == LAST) ? '0 : load_idx + IW'(1);
            // First word of a batch restarts the sticky flag.
            err_q <= ((load_idx == '0) ? 1'b0 : err_q) | !is_therm(64'(bus.in_data));
          end
        end
        SORT: begin
          store[pi] <= mn;
          store[pj] <= mx;
          if (last_pair) begin
            round <= round + IW'(1);
            pi    <= round[0] ? '0 : IW'(1);
          end else begin
            pi <= pi + IW'(2);
          end
        end
        DRAIN: begin
          if (out_hs) out_idx <= (out_idx == LAST) ? '0 : out_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_therm_sort_sched.sv
// Scoreboard bench for therm_sort_sched: a K=4 and a K=3 instance share one clock.
module tb_therm_sort_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  therm_sort_sched_if #(.N(4)) b4 ();
  therm_sort_sched_if #(.N(4)) b3 ();

  therm_sort_sched #(.N(4), .K(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  therm_sort_sched #(.N(4), .K(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  int passed = 0;
  int total  = 0;
  logic [4:0] q4[$];
  logic [4:0] q3[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Monitors: compare every presented word against the scoreboard head,
  // pop only when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && b4.out_valid) begin
      if (q4.size() == 0) begin
        total++;
        $display("FAIL k4 unexpected output: got %b want none", b4.out_data);
      end else begin
        chk("k4 out_data", b4.out_data, q4[0][3:0]);
        chk("k4 out_last", b4.out_last, q4[0][4]);
        if (b4.out_ready) void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b3.out_valid) begin
      if (q3.size() == 0) begin
        total++;
        $display("FAIL k3 unexpected output: got %b want none", b3.out_data);
      end else begin
        chk("k3 out_data", b3.out_data, q3[0][3:0]);
        chk("k3 out_last", b3.out_last, q3[0][4]);
        if (b3.out_ready) void'(q3.pop_front());
      end
    end
  end

  // {in_ready, out_valid, busy, err}
  function automatic logic [3:0] flags(input int k);
    if (k == 4) return {b4.in_ready, b4.out_valid, b4.busy, b4.err};
    return {b3.in_ready, b3.out_valid, b3.busy, b3.err};
  endfunction

  function automatic int qn(input int k);
    return (k == 4) ? q4.size() : q3.size();
  endfunction

  task automatic set_in(input int k, input bit v, input logic [3:0] d);
    if (k == 4) begin b4.in_valid = v; b4.in_data = d; end
    else        begin b3.in_valid = v; b3.in_data = d; end
  endtask

  task automatic set_or(input int k, input bit r);
    if (k == 4) b4.out_ready = r;
    else        b3.out_ready = r;
  endtask

  task automatic push(input int k, input logic [3:0] d, input bit last);
    if (k == 4) q4.push_back({last, d});
    else        q3.push_back({last, d});
  endtask

  // Words are read left to right from ws[15:12] downward; e1 is err after the first handshake.
  task automatic load(input int k, input logic [15:0] ws, output bit e1);
    e1 = 1'b0;
    for (int i = 0; i < k; i++) begin
      set_in(k, 1'b1, ws[15-4*i -: 4]);
      @(posedge clk); #1;
      if (i == 0) e1 = flags(k)[0];
    end
    set_in(k, 1'b0, 4'd0);
  endtask

  // Counts edges after the final input handshake edge until out_valid is seen.
  task automatic wait_valid(input int k, input int exp_lat, input string nm);
    int n;
    n = 0;
    while (!flags(k)[2] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, exp_lat);
  endtask

  task automatic drain(input int k, input logic [15:0] pat, input int plen);
    int n;
    n = 0;
    while (qn(k) > 0 && n < 100) begin
      set_or(k, (n < plen) ? pat[plen-1-n] : 1'b1);
      chk("in_ready low while draining", int'(flags(k)[3]), 0);
      @(posedge clk); #1;
      n++;
    end
    if (qn(k) > 0) begin
      total++;
      $display("FAIL drain timeout k=%0d: got %0d words left want 0", k, qn(k));
    end
    chk("in_ready after out_last", int'(flags(k)[3]), 1);
    chk("out_valid after out_last", int'(flags(k)[2]), 0);
    chk("busy after out_last", int'(flags(k)[1]), 0);
    set_or(k, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit e1;
    rst = 1'b1;
    set_in(4, 1'b0, 4'd0); set_in(3, 1'b0, 4'd0);
    set_or(4, 1'b0);       set_or(3, 1'b0);
    @(posedge clk); #1;
    chk("reset flags k4", flags(4), 4'b1000);
    chk("reset flags k3", flags(3), 4'b1000);
    chk("reset out_data k4", b4.out_data, 0);
    chk("reset out_last k4", b4.out_last, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic sort
    push(4, 4'b0001, 0); push(4, 4'b0011, 0); push(4, 4'b0111, 0); push(4, 4'b1111, 1);
    load(4, 16'b0111_0001_1111_0011, e1);
    chk("basic err first", e1, 0);
    wait_valid(4, 6, "basic latency");
    drain(4, 16'hFFFF, 0);
    chk("basic err", flags(4)[0], 0);

    // Backpressure on the same batch
    push(4, 4'b0001, 0); push(4, 4'b0011, 0); push(4, 4'b0111, 0); push(4, 4'b1111, 1);
    load(4, 16'b0111_0001_1111_0011, e1);
    wait_valid(4, 6, "bp latency");
    drain(4, 16'b0000_0000_0100_1011, 7);

    // Invalid code: column sort, sticky err through sort and drain
    push(4, 4'b0000, 0); push(4, 4'b0001, 0); push(4, 4'b0111, 0); push(4, 4'b1111, 1);
    load(4, 16'b0101_0011_0000_1111, e1);
    chk("invalid err first", e1, 1);
    wait_valid(4, 6, "invalid latency");
    chk("invalid err in drain", flags(4)[0], 1);
    drain(4, 16'hFFFF, 0);
    chk("invalid err held", flags(4)[0], 1);

    // Duplicates and extremes; first valid handshake clears err
    push(4, 4'b0000, 0); push(4, 4'b0000, 0); push(4, 4'b1111, 0); push(4, 4'b1111, 1);
    load(4, 16'b0000_1111_0000_1111, e1);
    chk("dup err cleared", e1, 0);
    wait_valid(4, 6, "dup latency");
    drain(4, 16'hFFFF, 0);
    chk("dup err", flags(4)[0], 0);

    // Reset during the third SORT cycle
    load(4, 16'b0101_1111_0000_0011, e1);
    chk("abort err first", e1, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort flags", flags(4), 4'b1000);
    chk("abort out_data", b4.out_data, 0);
    push(4, 4'b0000, 0); push(4, 4'b0001, 0); push(4, 4'b0111, 0); push(4, 4'b1111, 1);
    load(4, 16'b1111_0000_0111_0001, e1);
    wait_valid(4, 6, "post-abort latency");
    drain(4, 16'hFFFF, 0);

    // Odd K, back-to-back batches
    push(3, 4'b0000, 0); push(3, 4'b0011, 0); push(3, 4'b0111, 1);
    load(3, 16'b0111_0000_0011_0000, e1);
    wait_valid(3, 3, "k3 latency");
    drain(3, 16'hFFFF, 0);
    push(3, 4'b0000, 0); push(3, 4'b0001, 0); push(3, 4'b0111, 1);
    load(3, 16'b0001_0111_0000_0000, e1);
    wait_valid(3, 3, "k3 b2b latency");
    drain(3, 16'hFFFF, 0);
    chk("k3 err", flags(3)[0], 0);

    chk("k4 scoreboard empty", q4.size(), 0);
    chk("k3 scoreboard empty", q3.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
